// File: rtl/cam_frame_writer_if.sv
// Write-burst handshake between cam_frame_writer (master) and the sdram_top write port (slave).
interface cam_frame_writer_if;
    logic        wr_sdram_req;
    logic        wr_sdram_ack;
    logic [23:0] wr_sdram_add;

    modport master (
        output wr_sdram_req,
        output wr_sdram_add,
        input  wr_sdram_ack
    );

    modport slave (
        input  wr_sdram_req,
        input  wr_sdram_add,
        output wr_sdram_ack
    );
endinterface

// File: rtl/cam_frame_writer.sv
// Issues one SDRAM write burst per camera row while the write FIFO holds enough data.
// Frames start on the VSYNC falling edge; tracks per-frame burst counts and FIFO overflow.
module cam_frame_writer #(
    parameter int unsigned BURST_LEN      = 512,
    parameter int unsigned ROWS_PER_FRAME = 750,
    parameter int unsigned LEVEL_TH       = 512,
    parameter int unsigned OVF_TH         = 2040
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      cam_vsyn,
    input  logic [1:0]                cam_bank,
    input  logic [10:0]               fifo_used,
    cam_frame_writer_if.master        sdram,
    output logic                      clear_fifo,
    output logic                      frame_done,
    output logic [12:0]               burst_cnt_r,
    output logic                      overflow
);

    // Column field is one full burst wide and always starts at 0.
    localparam int unsigned ColBits = $clog2(BURST_LEN);
    localparam logic [10:0] LevelTh = 11'(LEVEL_TH);
    localparam logic [10:0] OvfTh   = 11'(OVF_TH);
    localparam logic [12:0] RowsMax = 13'(ROWS_PER_FRAME);

    typedef enum logic [2:0] {StIdle, StArm, StReq, StCool, StDone} state_e;

    state_e      state_q, state_d;
    logic        v1, v2;
    logic        lvl_ok_d1, lvl_ok_d2;
    logic        ovf_d1, ovf_d2;
    logic        cool_q;
    logic        start_pend;
    logic [12:0] row_q;
    logic [12:0] count_q;
    logic [1:0]  bank_q;

    logic        fstart;
    logic        start_now;
    logic        ack_in_req;
    logic [12:0] row_next;
    logic        last_row;

    assign fstart     = ~v1 & v2;
    // A start seen during REQ is deferred until the burst has been acked.
    assign start_now  = (state_q != StReq) & (fstart | start_pend);
    assign ack_in_req = (state_q == StReq) & sdram.wr_sdram_ack;
    assign row_next   = row_q + 13'd1;
    assign last_row   = (row_next == RowsMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_now) begin
            state_d = StArm;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StArm: begin
                    if (enable && lvl_ok_d2 && (row_q < RowsMax)) begin
                        state_d = StReq;
                    end
                end
                StReq: begin
                    if (ack_in_req) begin
                        state_d = last_row ? StDone : StCool;
                    end
                end
                StCool: begin
                    if (cool_q) begin
                        state_d = StArm;
                    end
                end
                StDone: state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        sdram.wr_sdram_req = (state_q == StReq);
        sdram.wr_sdram_add = {bank_q, row_q, {ColBits{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            lvl_ok_d1   <= 1'b0;
            lvl_ok_d2   <= 1'b0;
            ovf_d1      <= 1'b0;
            ovf_d2      <= 1'b0;
            overflow    <= 1'b0;
            clear_fifo  <= 1'b0;
            frame_done  <= 1'b0;
            cool_q      <= 1'b0;
            start_pend  <= 1'b0;
            row_q       <= '0;
            count_q     <= '0;
            bank_q      <= '0;
            burst_cnt_r <= '0;
        end else begin
            v1         <= cam_vsyn;
            v2         <= v1;
            lvl_ok_d1  <= (fifo_used >= LevelTh);
            lvl_ok_d2  <= lvl_ok_d1;
            ovf_d1     <= (fifo_used >= OvfTh);
            ovf_d2     <= ovf_d1;
            overflow   <= overflow | ovf_d2;
            clear_fifo <= start_now;
            frame_done <= ack_in_req & last_row;
            cool_q     <= (state_q == StCool) & ~cool_q;

            if (start_now) begin
                row_q       <= '0;
                bank_q      <= cam_bank;
                burst_cnt_r <= count_q;
                count_q     <= '0;
                start_pend  <= 1'b0;
            end else begin
                if (ack_in_req) begin
                    row_q   <= row_next;
                    count_q <= count_q + 13'd1;
                end
                if ((state_q == StReq) && fstart) begin
                    start_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Randomized scoreboard bench for cam_frame_writer: a transaction-level frame model predicts
// burst addresses, frame-start pulses and frame-done pulses; a monitor compares them.
module tb_cam_frame_writer;

    localparam int Rows = 750;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        cam_vsyn;
    logic [1:0]  cam_bank;
    logic [10:0] fifo_used;
    logic        clear_fifo;
    logic        frame_done;
    logic [12:0] burst_cnt_r;
    logic        overflow;

    cam_frame_writer_if bus ();

    cam_frame_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cam_vsyn    (cam_vsyn),
        .cam_bank    (cam_bank),
        .fifo_used   (fifo_used),
        .sdram       (bus),
        .clear_fifo  (clear_fifo),
        .frame_done  (frame_done),
        .burst_cnt_r (burst_cnt_r),
        .overflow    (overflow)
    );

    always #4 clk = ~clk;

    int n_cmp;
    int n_err;

    // Scoreboard queues: expected request addresses, {burst count, address} at frame start,
    // and the address shown when the frame completes.
    logic [23:0] addr_q[$];
    logic [36:0] clr_q[$];
    logic [23:0] done_q[$];

    int         mrow;
    int         mcount;
    logic [1:0] mbank;

    function automatic logic [23:0] exp_addr(input logic [1:0] b, input int r);
        return {b, 13'(r), 9'd0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_ack();
        mrow++;
        mcount++;
        if (mrow == Rows) done_q.push_back(exp_addr(mbank, mrow));
        else addr_q.push_back(exp_addr(mbank, mrow));
    endtask

    // A new frame cancels any row request not yet issued and restarts at row 0.
    task automatic model_start(input logic [1:0] b);
        addr_q.delete();
        clr_q.push_back({13'(mcount), exp_addr(b, 0)});
        mbank  = b;
        mrow   = 0;
        mcount = 0;
        addr_q.push_back(exp_addr(b, 0));
    endtask

    task automatic fall_vsyn(input logic [1:0] b);
        cam_bank = b;
        if (!cam_vsyn) begin
            cam_vsyn = 1'b1;
            cycles(3);
        end
        cam_vsyn = 1'b0;
        cycles(3);
        cam_vsyn = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.wr_sdram_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_seen", 64'(bus.wr_sdram_req), 64'(1));
    endtask

    task automatic burst();
        bit ok;
        wait_req(ok);
        if (!ok) return;
        cycles(int'($urandom_range(0, 3)));
        bus.wr_sdram_ack = 1'b1;
        model_ack();
        @(negedge clk);
        bus.wr_sdram_ack = 1'b0;
    endtask

    task automatic burst_with_fall(input logic [1:0] b);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        fall_vsyn(b);
        check("req_held_pending", 64'(bus.wr_sdram_req), 64'(1));
        bus.wr_sdram_ack = 1'b1;
        model_ack();
        model_start(b);
        @(negedge clk);
        bus.wr_sdram_ack = 1'b0;
    endtask

    task automatic no_req_for(input string name, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen |= bus.wr_sdram_req;
        end
        check(name, 64'(seen), 64'(0));
    endtask

    task automatic park_and_fall(input logic [1:0] b);
        fifo_used = 11'd100;
        cycles(8);
        model_start(b);
        fall_vsyn(b);
        fifo_used = 11'($urandom_range(512, 1500));
    endtask

    initial begin : monitor
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.wr_sdram_req && !prev) begin
                    if (addr_q.size() == 0) check("req_unexpected", 64'(bus.wr_sdram_req), 64'(0));
                    else check("req_addr", 64'(bus.wr_sdram_add), 64'(addr_q.pop_front()));
                end
                if (clear_fifo) begin
                    if (clr_q.size() == 0) check("clear_unexpected", 64'(clear_fifo), 64'(0));
                    else check("start_cnt_addr", 64'({burst_cnt_r, bus.wr_sdram_add}),
                               64'(clr_q.pop_front()));
                end
                if (frame_done) begin
                    if (done_q.size() == 0) check("done_unexpected", 64'(frame_done), 64'(0));
                    else check("done_addr", 64'(bus.wr_sdram_add), 64'(done_q.pop_front()));
                end
                prev = bus.wr_sdram_req;
            end else begin
                prev = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1);
    end

    initial begin : stimulus
        bit ok;
        logic [1:0] b;
        n_cmp = 0;
        n_err = 0;
        mrow = 0;
        mcount = 0;
        mbank = 2'd0;
        rst_n = 1'b0;
        enable = 1'b1;
        cam_vsyn = 1'b0;
        cam_bank = 2'd0;
        fifo_used = 11'd0;
        bus.wr_sdram_ack = 1'b0;

        cycles(3);
        check("rst_req", 64'(bus.wr_sdram_req), 64'(0));
        check("rst_addr", 64'(bus.wr_sdram_add), 64'(0));
        check("rst_clear", 64'(clear_fifo), 64'(0));
        check("rst_done", 64'(frame_done), 64'(0));
        check("rst_burst_cnt", 64'(burst_cnt_r), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        cycles(2);

        // One-cycle overflow level shows up three clocks later and sticks.
        fifo_used = 11'd2045;
        cycles(1);
        fifo_used = 11'd600;
        cycles(1);
        check("overflow_not_yet", 64'(overflow), 64'(0));
        cycles(1);
        check("overflow_set", 64'(overflow), 64'(1));

        no_req_for("idle_no_req", 20);

        // Full frame from IDLE.
        b = 2'($urandom_range(0, 3));
        model_start(b);
        fall_vsyn(b);
        for (int i = 0; i < Rows; i++) burst();
        no_req_for("done_no_req", 20);
        check("overflow_sticky_1", 64'(overflow), 64'(1));

        // Start from DONE, then a start arriving while a burst is outstanding at row 5.
        b = 2'($urandom_range(0, 3));
        model_start(b);
        fall_vsyn(b);
        for (int i = 0; i < 5; i++) burst();
        burst_with_fall(2'($urandom_range(0, 3)));

        // Level drop parks the writer; enable gates new requests only.
        for (int i = 0; i < 4; i++) burst();
        fifo_used = 11'd100;
        no_req_for("low_level_no_req", 15);
        enable = 1'b0;
        fifo_used = 11'd1000;
        no_req_for("disabled_no_req", 10);
        enable = 1'b1;
        cycles(1);
        check("enable_req_1clk", 64'(bus.wr_sdram_req), 64'(1));
        burst();
        park_and_fall(2'($urandom_range(0, 3)));
        for (int i = 0; i < 3; i++) burst();

        for (int f = 0; f < 6; f++) begin
            int nb;
            nb = int'($urandom_range(2, 12));
            for (int i = 0; i < nb; i++) begin
                fifo_used = 11'($urandom_range(512, 2039));
                burst();
            end
            if ($urandom_range(0, 1) == 1) burst_with_fall(2'($urandom_range(0, 3)));
            else park_and_fall(2'($urandom_range(0, 3)));
        end

        fifo_used = 11'd900;
        burst();
        check("overflow_sticky_2", 64'(overflow), 64'(1));
        check("clr_q_drained", 64'(clr_q.size()), 64'(0));
        check("done_q_drained", 64'(done_q.size()), 64'(0));

        // Reset in the middle of a burst drops the request at once.
        wait_req(ok);
        cycles(1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", 64'(bus.wr_sdram_req), 64'(0));
        check("rst_mid_overflow", 64'(overflow), 64'(0));
        addr_q.delete();
        clr_q.delete();
        done_q.delete();
        cycles(2);
        rst_n = 1'b1;
        fifo_used = 11'd600;
        no_req_for("post_rst_no_req", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
